// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - clip ids, default widths, ROM entry layout and FSM states for sfx_scheduler
package sfx_pkg;

  localparam int DEF_NOTE_W = 6;
  localparam int DEF_DUR_W  = 8;
  localparam int DEF_IDX_W  = 5;
  localparam int NUM_SFX    = 5;

  // Clip ids double as priority: a higher id outranks a lower one.
  localparam logic [2:0] SFX_NONE  = 3'd0;
  localparam logic [2:0] SFX_CLICK = 3'd1;
  localparam logic [2:0] SFX_SCORE = 3'd2;
  localparam logic [2:0] SFX_LIFE  = 3'd3;
  localparam logic [2:0] SFX_LOSE  = 3'd4;
  localparam logic [2:0] SFX_WIN   = 3'd5;

  // Pending bits discarded when a game-over clip (win or lose) is selected.
  localparam logic [NUM_SFX-1:0] MINOR_MASK = 5'b00111;

  typedef struct packed {
    logic [DEF_NOTE_W-1:0] note;
    logic [DEF_DUR_W-1:0]  dur;
    logic                  last;
  } rom_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY
  } state_t;

endpackage

// File: rtl/sfx_rom.sv
// rtl/sfx_rom.sv - combinational clip table lookup (clip, idx) -> {note, dur, last}
module sfx_rom
  import sfx_pkg::*;
(
  input  logic [2:0]           clip,
  input  logic [DEF_IDX_W-1:0] idx,
  output rom_entry_t           entry
);

  logic [DEF_NOTE_W-1:0] n;
  logic [DEF_DUR_W-1:0]  d;
  logic [DEF_IDX_W-1:0]  last_idx;

  // Clip tables; an index past the end returns the final entry so reads stay in range.
  always_comb begin
    n        = '0;
    d        = 8'd1;
    last_idx = '0;
    case (clip)
      SFX_CLICK: begin
        last_idx = 5'd3;
        case (idx)
          5'd0:    {n, d} = {6'd19, 8'd30};
          5'd1:    {n, d} = {6'd17, 8'd20};
          5'd2:    {n, d} = {6'd16, 8'd20};
          default: {n, d} = {6'd15, 8'd30};
        endcase
      end
      SFX_SCORE: begin
        last_idx = 5'd3;
        case (idx)
          5'd0:    {n, d} = {6'd13, 8'd30};
          5'd1:    {n, d} = {6'd17, 8'd30};
          5'd2:    {n, d} = {6'd20, 8'd30};
          default: {n, d} = {6'd26, 8'd30};
        endcase
      end
      SFX_LIFE: begin
        last_idx = 5'd5;
        case (idx)
          5'd0:    {n, d} = {6'd36, 8'd20};
          5'd1:    {n, d} = {6'd34, 8'd20};
          5'd2:    {n, d} = {6'd30, 8'd20};
          5'd3:    {n, d} = {6'd26, 8'd30};
          5'd4:    {n, d} = {6'd18, 8'd30};
          default: {n, d} = {6'd12, 8'd50};
        endcase
      end
      SFX_LOSE: begin
        last_idx = 5'd7;
        case (idx)
          5'd0:    {n, d} = {6'd10, 8'd100};
          5'd1:    {n, d} = {6'd8,  8'd100};
          5'd2:    {n, d} = {6'd10, 8'd200};
          5'd3:    {n, d} = {6'd0,  8'd110};
          5'd4:    {n, d} = {6'd6,  8'd150};
          5'd5:    {n, d} = {6'd7,  8'd150};
          5'd6:    {n, d} = {6'd3,  8'd150};
          default: {n, d} = {6'd4,  8'd150};
        endcase
      end
      SFX_WIN: begin
        last_idx = 5'd18;
        case (idx)
          5'd0, 5'd3:                     {n, d} = {6'd14, 8'd100};
          5'd1, 5'd4:                     {n, d} = {6'd10, 8'd100};
          5'd2, 5'd5:                     {n, d} = {6'd7,  8'd100};
          5'd6, 5'd7:                     {n, d} = {6'd14, 8'd200};
          5'd8, 5'd11:                    {n, d} = {6'd16, 8'd100};
          5'd9, 5'd12:                    {n, d} = {6'd12, 8'd100};
          5'd10, 5'd13:                   {n, d} = {6'd9,  8'd100};
          5'd14, 5'd15:                   {n, d} = {6'd16, 8'd200};
          default:                        {n, d} = {6'd18, 8'd200};
        endcase
      end
      default: begin
        n        = '0;
        d        = 8'd1;
        last_idx = '0;
      end
    endcase
  end

  assign entry.note = n;
  assign entry.dur  = d;
  assign entry.last = (idx >= last_idx);

endmodule

// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - fixed-priority buzzer clip scheduler; SFX_PREEMPT_EN lets higher-priority requests abort a clip
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int DUR_W  = DEF_DUR_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              tick,
  input  logic [4:0]        req,
  output logic [NOTE_W-1:0] note,
  output logic              busy,
  output logic [2:0]        cur_sfx,
  output logic              done
);

  state_t               state_q, state_d;
  logic [NUM_SFX-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DUR_W-1:0]     dur_q, dur_d;
  logic [NOTE_W-1:0]    note_q, note_d;
  logic [2:0]           cur_q, cur_d;
  logic                 done_q, done_d;
  logic [2:0]           sel_id;
  logic [NUM_SFX-1:0]   sel_hot;
  logic [NUM_SFX-1:0]   clr;
  rom_entry_t           rom_e;

  sfx_rom u_rom (
    .clip  (cur_q),
    .idx   (DEF_IDX_W'(idx_q)),
    .entry (rom_e)
  );

  // Priority encoder: later iterations overwrite earlier ones, so the highest id wins.
  always_comb begin
    sel_id  = SFX_NONE;
    sel_hot = '0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (pending_q[i]) begin
        sel_id     = 3'(i + 1);
        sel_hot    = '0;
        sel_hot[i] = 1'b1;
      end
    end
  end

`ifdef SFX_PREEMPT_EN
  logic preempt;

  // A pending clip with a higher id than the active one outranks it.
  always_comb begin
    preempt = 1'b0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (pending_q[i] && (3'(i + 1) > cur_q)) preempt = 1'b1;
    end
  end
`endif

  // Next state, pending update and next output register values.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    dur_d     = dur_q;
    note_d    = note_q;
    cur_d     = cur_q;
    done_d    = 1'b0;
    clr       = '0;
    if (!enable) begin
      state_d   = S_IDLE;
      pending_d = '0;
      idx_d     = '0;
      dur_d     = '0;
      note_d    = '0;
      cur_d     = SFX_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            cur_d = sel_id;
            clr   = sel_hot;
            if (sel_id == SFX_WIN || sel_id == SFX_LOSE) clr = clr | MINOR_MASK;
            idx_d   = '0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          note_d  = NOTE_W'(rom_e.note);
          dur_d   = (rom_e.dur == '0) ? DUR_W'(1) : DUR_W'(rom_e.dur);
          state_d = S_PLAY;
        end
        S_PLAY: begin
          if (tick) begin
            if (dur_q == DUR_W'(1)) begin
              if (rom_e.last) begin
                note_d  = '0;
                done_d  = 1'b1;
                cur_d   = SFX_NONE;
                state_d = S_IDLE;
              end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_LOAD;
              end
            end else begin
              dur_d = dur_q - DUR_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
`ifdef SFX_PREEMPT_EN
      if ((state_q != S_IDLE) && preempt) begin
        state_d = S_IDLE;
        note_d  = '0;
        cur_d   = SFX_NONE;
        done_d  = 1'b0;
        idx_d   = '0;
      end
`endif
      // A request landing on the selection cycle survives the clear.
      pending_d = (pending_q & ~clr) | req;
    end
  end

  // State, pending latches and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      dur_q     <= '0;
      note_q    <= '0;
      cur_q     <= SFX_NONE;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      dur_q     <= dur_d;
      note_q    <= note_d;
      cur_q     <= cur_d;
      done_q    <= done_d;
    end
  end

  assign note    = note_q;
  assign busy    = (state_q != S_IDLE);
  assign cur_sfx = cur_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb/tb_sfx_scheduler.sv - scoreboard bench for sfx_scheduler (honours SFX_PREEMPT_EN)
module tb_sfx_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       tick = 1'b0;
  logic [4:0] req = '0;
  logic [5:0] note;
  logic       busy;
  logic [2:0] cur_sfx;
  logic       done;

  typedef struct {
    int note;
    int ticks;
    int done;
    int cur;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  done_seen = 0;
  int  done_exp = 0;
  int  tcyc = 0;

  sfx_scheduler dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .tick    (tick),
    .req     (req),
    .note    (note),
    .busy    (busy),
    .cur_sfx (cur_sfx),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Timebase: one tick every fourth cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tcyc++;
      tick = (tcyc % 4 == 0);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_ev(input int n, input int t, input int d, input int c);
    ev_t e;
    e.note  = n;
    e.ticks = t;
    e.done  = d;
    e.cur   = c;
    exp_q.push_back(e);
  endtask

  // Expected note-change events for the first 'upto' entries of a clip.
  // Equal consecutive notes merge into one event; the first note's tick count is not checked.
  task automatic push_clip(input int id, input int upto);
    int n[$];
    int d[$];
    int run;
    int lim;
    case (id)
      1: begin n = '{19, 17, 16, 15}; d = '{30, 20, 20, 30}; end
      2: begin n = '{13, 17, 20, 26}; d = '{30, 30, 30, 30}; end
      3: begin n = '{36, 34, 30, 26, 18, 12}; d = '{20, 20, 20, 30, 30, 50}; end
      4: begin n = '{10, 8, 10, 0, 6, 7, 3, 4}; d = '{100, 100, 200, 110, 150, 150, 150, 150}; end
      default: begin
        n = '{14, 10, 7, 14, 10, 7, 14, 14, 16, 12, 9, 16, 12, 9, 16, 16, 18, 18, 18};
        d = '{100, 100, 100, 100, 100, 100, 200, 200, 100, 100, 100, 100, 100, 100, 200, 200, 200, 200, 200};
      end
    endcase
    lim = (upto > n.size()) ? n.size() : upto;
    run = 0;
    for (int i = 0; i < lim; i++) begin
      if (i == 0) begin
        push_ev(n[i], -1, 0, id);
        run = 0;
      end else if (n[i] != n[i-1]) begin
        push_ev(n[i], run, 0, id);
        run = 0;
      end
      run += d[i];
    end
    if (lim == n.size()) begin
      push_ev(0, run, 1, 0);
      done_exp++;
    end
  endtask

  // Monitor: every change of 'note' pops one expected event; ticks are counted while busy.
  initial begin
    int   last_note;
    int   tcount;
    int   ev_no;
    ev_t  e;
    last_note = 0;
    tcount    = 0;
    ev_no     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_note = 0;
        tcount    = 0;
      end else begin
        if (done) done_seen++;
        if (int'(note) != last_note) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event#%0d: unexpected note=%0d done=%0d cur=%0d", ev_no, note, done, cur_sfx);
          end else begin
            e = exp_q.pop_front();
            if (int'(note) != e.note || int'(done) != e.done || int'(cur_sfx) != e.cur ||
                (e.ticks >= 0 && tcount != e.ticks)) begin
              errors++;
              $display("FAIL event#%0d: got note=%0d ticks=%0d done=%0d cur=%0d, expected note=%0d ticks=%0d done=%0d cur=%0d",
                       ev_no, note, tcount, done, cur_sfx, e.note, e.ticks, e.done, e.cur);
            end
          end
          ev_no++;
          last_note = int'(note);
          tcount    = 0;
        end
        if (busy && tick) tcount++;
      end
    end
  end

  task automatic pulse(input logic [4:0] r);
    @(posedge clk);
    #1 req = r;
    @(posedge clk);
    #1 req = '0;
  endtask

  task automatic wait_q(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (exp_q.size() > n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() > n) begin
      errors++;
      $display("FAIL %s: timeout with %0d events outstanding, expected at most %0d", nm, exp_q.size(), n);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_note", int'(note), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cur", int'(cur_sfx), 0);
    chk("reset_done", int'(done), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single click with request-to-note latency
    push_clip(1, 99);
    @(posedge clk);
    #1 req = 5'b00001;
    @(posedge clk);
    #1 req = '0;
    @(negedge clk);
    chk("lat_c1_busy", int'(busy), 0);
    @(negedge clk);
    chk("lat_c2_busy", int'(busy), 1);
    chk("lat_c2_cur", int'(cur_sfx), 1);
    chk("lat_c2_note", int'(note), 0);
    @(negedge clk);
    chk("lat_c3_note", int'(note), 19);
    wait_q(0, 3000, "click_done");
    @(negedge clk);
    chk("click_end_busy", int'(busy), 0);
    chk("click_end_cur", int'(cur_sfx), 0);

    // Click and score together: score first, then click
    push_clip(2, 99);
    push_clip(1, 99);
    pulse(5'b00011);
    wait_q(0, 3000, "score_click");
    repeat (3) @(negedge clk);

    // Request on the selection cycle re-arms the same clip
    push_clip(1, 99);
    push_clip(1, 99);
    @(posedge clk);
    #1 req = 5'b00001;
    @(posedge clk);
    @(posedge clk);
    #1 req = '0;
    wait_q(0, 3000, "click_replay");
    repeat (3) @(negedge clk);

    // Lose requested during click playback
`ifdef SFX_PREEMPT_EN
    push_clip(1, 1);
    push_ev(0, -1, 0, 0);
    push_clip(4, 99);
`else
    push_clip(1, 99);
    push_clip(4, 99);
`endif
    pulse(5'b00001);
    wait_q(exp_q.size() - 1, 500, "click_first_note");
    @(posedge clk);
    #1 req = 5'b01000;
    @(posedge clk);
    #1 req = '0;
    @(negedge clk);
    chk("pre_abort_note", int'(note), 19);
    @(negedge clk);
`ifdef SFX_PREEMPT_EN
    chk("abort_note", int'(note), 0);
`else
    chk("no_abort_note", int'(note), 19);
`endif
    wait_q(0, 8000, "lose_after_click");
    repeat (3) @(negedge clk);

    // Win with click and score pending at selection: the minor clips are discarded
    push_clip(5, 99);
    pulse(5'b10011);
    wait_q(0, 20000, "win_done");
    repeat (6) @(negedge clk);
    chk("win_after_busy", int'(busy), 0);
    chk("win_after_cur", int'(cur_sfx), 0);

    // Enable dropped mid-life; a request while disabled is ignored
    push_clip(3, 2);
    push_ev(0, -1, 0, 0);
    pulse(5'b00100);
    wait_q(1, 1000, "life_two_notes");
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    chk("dis_same_cycle_busy", int'(busy), 1);
    @(negedge clk);
    chk("dis_note", int'(note), 0);
    chk("dis_busy", int'(busy), 0);
    chk("dis_cur", int'(cur_sfx), 0);
    pulse(5'b00100);
    repeat (5) @(posedge clk);
    #1 enable = 1'b1;
    repeat (200) @(negedge clk);
    chk("reen_busy", int'(busy), 0);
    chk("reen_note", int'(note), 0);
    wait_q(0, 1, "disable_events");

    // Asynchronous reset mid-lose, asserted while tick is high
    push_clip(4, 2);
    pulse(5'b01000);
    wait_q(0, 2000, "lose_two_notes");
    repeat (50) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #2;
      if (tick) break;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_note", int'(note), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_cur", int'(cur_sfx), 0);
    chk("arst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("post_rst_note", int'(note), 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_cur", int'(cur_sfx), 0);

    chk("done_count", done_seen, done_exp);
    chk("leftover_events", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sfx_scheduler.md
# sfx_scheduler

Sound-effect scheduler for the game's single buzzer. Accepts one-cycle requests from five game events (click, score, life lost, lose, win), arbitrates them by fixed priority with pending latches, and sequences the selected clip note-by-note from a clip ROM. It drives a 6-bit note code to the tone generator, with note durations counted in external `tick` strobes from the clock divider.

## Interface
- `NOTE_W`, 6: note code width; 0 = silence.
- `DUR_W`, 8: per-note duration width, in ticks.
- `IDX_W`, 5: note index width within a clip.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: sound enable; low forces silence.
- `tick` in 1: one-cycle timebase strobe.
- `req` in 5: one-cycle request pulses. Bit 0 click, 1 score, 2 life, 3 lose, 4 win.
- `note` out NOTE_W: registered note code to the tone generator.
- `busy` out 1: a clip is loaded or playing.
- `cur_sfx` out 3: id of the active clip. 0 none, 1 click, 2 score, 3 life, 4 lose, 5 win.
- `done` out 1: one-cycle pulse when a clip ends naturally.

## Operation
- Priority, high to low: win > lose > life > score > click.
- Each `req` bit sets its `pending` bit on the sampling edge. A bit already set stays set; there is no counting.
- States:
  - IDLE: if any pending bit is set, select the highest-priority one, clear its pending bit, set idx=0, and go to LOAD.
  - LOAD: read ROM(clip, idx) = {note, dur, last}. Register `note`, load dur_cnt = max(dur,1), then go to PLAY.
  - PLAY: on `tick`, dur_cnt decrements. On `tick` with dur_cnt==1:
    - if last: note=0, pulse `done`, go to IDLE;
    - else: idx+1, go to LOAD.
- Selecting win or lose also clears the pending bits of click, score and life.
- A request for the clip already playing sets its pending bit, so the clip replays after the current one finishes.
- `enable` low:
  - Go to IDLE immediately; note=0, pending cleared, cur_sfx=0.
  - `req` is ignored and `done` is not pulsed.
- The ROM never returns idx beyond the clip's `last` entry. idx does not wrap.
- Clip contents, as (note, dur) pairs in play order:
  - click: (19,30)(17,20)(16,20)(15,30)
  - score: (13,30)(17,30)(20,30)(26,30)
  - life: (36,20)(34,20)(30,20)(26,30)(18,30)(12,50)
  - lose: (10,100)(8,100)(10,200)(0,110)(6,150)(7,150)(3,150)(4,150)
  - win: 19 entries, (14,100)(10,100)(7,100)(14,100)(10,100)(7,100)(14,200)(14,200)(16,100)(12,100)(9,100)(16,100)(12,100)(9,100)(16,200)(16,200)(18,200)(18,200)(18,200)
- A note code of 0 inside a clip is a rest. `busy` stays high during it.

## Timing
- Reset values: note=0, busy=0, cur_sfx=0, done=0, pending=0, state IDLE.
- Sequence for a `req` pulse in cycle 0, starting from IDLE:
  - pending is set at the end of cycle 0;
  - state is LOAD in cycle 2, with busy=1 and cur_sfx valid;
  - `note` is valid from cycle 3.
- A `tick` in the LOAD cycle is ignored. Each note is held for exactly dur ticks.
- Between notes, `note` holds the old value through the LOAD cycle. It changes on the edge that leaves LOAD, so there is no silent glitch.
- `done` and note=0 occur in the same cycle. `busy` drops in that cycle too, unless pending work exists; in that case `busy` re-asserts 1 cycle later.
- A `req` arriving in the same cycle the pending bit is cleared by selection re-sets that bit; set has priority over clear.
- Reset asserted mid-clip returns all outputs to reset values asynchronously.

## Configuration
- `SFX_PREEMPT_EN` defined:
  - In PLAY or LOAD, a pending bit strictly higher in priority than the active clip aborts the clip.
  - The abort goes to IDLE on the next edge with note=0 and no `done`.
  - The aborted clip is dropped.
- Undefined: clips always play to completion, and requests are served in priority order afterwards.

## Structure
- `sfx_pkg`:
  - clip id localparams (SFX_NONE..SFX_WIN), priority order;
  - NOTE_W / DUR_W / IDX_W defaults;
  - ROM entry struct/width constants.
- Sub-module `sfx_rom`: combinational lookup (clip, idx) -> {note, dur, last}. It holds all clip tables.
- Top-level `sfx_scheduler` holds the FSM, the pending register, the priority encoder and dur_cnt.

## Test plan
- `req[0]` once, tick every 4 cycles:
  - note = 19, 17, 16, 15 for 30, 20, 20, 30 ticks;
  - then note=0, one `done` pulse, cur_sfx returns to 0.
- `req[0]` and `req[1]` in the same cycle: score plays first (13,17,20,26), then click plays, giving 2 `done` pulses.
- `req[3]` during click playback:
  - without `SFX_PREEMPT_EN`, click finishes and then lose plays;
  - with it, note goes to 0 one edge after the pending bit is set, then lose starts with note=10, and click's `done` is never pulsed.
- `req[4]` while click and score are pending: win plays all 19 notes, and pending click/score are discarded (busy=0 after win's `done`).
- `enable` dropped in the middle of a life clip: note=0, busy=0 on the next edge; a `req[2]` while disabled produces no sound after re-enable.
- `rst_n` low mid-lose, including an edge inside a tick: all outputs are 0 immediately; after release, the FSM stays IDLE with no spurious note.
